// File: rtl/serial_rx_pkg.sv
// Shared state encoding and sizing helper for the serial word receiver.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_HOLD    = 2'd2
    } rx_state_e;

    // Bit-counter width for a word of n bits; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Bit counter: counts 0..LAST, wraps to 0 after LAST, flags the last position.
module rx_bit_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LAST  = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        tc_c    = (count_q == WIDTH'(LAST));
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tc_c ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver, MSB first, with hold/acknowledge handshake
// and a sticky overrun flag.
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int unsigned Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Serial_Input,
    input  logic                   Start,
    input  logic                   Shift,
    input  logic                   Sync_Reset,
    input  logic                   Data_Ack,
    output logic [Word_Length-1:0] Parallel_Output,
    output logic                   Data_Valid,
    output logic                   Busy,
    output logic                   Overrun
);

    localparam int unsigned CNT_W = cnt_width(Word_Length);

    rx_state_e              state_q, state_d;
    logic [Word_Length-1:0] sr_q, sr_d;
    logic [Word_Length-1:0] po_q, po_d;
    logic                   dv_q, dv_d;
    logic                   ovr_q, ovr_d;
    logic [Word_Length-1:0] sr_next;
    logic                   cnt_clear;
    logic                   cnt_enable;
    logic                   cnt_tc;

    rx_bit_counter #(
        .WIDTH (CNT_W),
        .LAST  (Word_Length - 1)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .tc_c   (cnt_tc)
    );

    assign sr_next = {sr_q[Word_Length-2:0], Serial_Input};

    // Next-state and datapath; Sync_Reset overrides everything.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        po_d       = po_q;
        dv_d       = dv_q;
        ovr_d      = ovr_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        if (Sync_Reset) begin
            state_d   = ST_IDLE;
            sr_d      = '0;
            po_d      = '0;
            dv_d      = 1'b0;
            ovr_d     = 1'b0;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_d   = ST_RECEIVE;
                        cnt_clear = 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    if (Shift) begin
                        sr_d       = sr_next;
                        cnt_enable = 1'b1;
                        if (cnt_tc) begin
                            po_d    = sr_next;
                            dv_d    = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Data_Ack) begin
                        dv_d = 1'b0;
                        if (Start) begin
                            state_d   = ST_RECEIVE;
                            cnt_clear = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (Start) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            po_q    <= '0;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            po_q    <= po_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Parallel_Output = po_q;
    assign Data_Valid      = dv_q;
    assign Overrun         = ovr_q;
    assign Busy            = (state_q == ST_RECEIVE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver with Word_Length = 8.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       Serial_Input;
    logic       Start;
    logic       Shift;
    logic       Sync_Reset;
    logic       Data_Ack;
    logic [7:0] Parallel_Output;
    logic       Data_Valid;
    logic       Busy;
    logic       Overrun;

    int checks = 0;
    int errors = 0;

    serial_word_receiver #(.Word_Length(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .Serial_Input    (Serial_Input),
        .Start           (Start),
        .Shift           (Shift),
        .Sync_Reset      (Sync_Reset),
        .Data_Ack        (Data_Ack),
        .Parallel_Output (Parallel_Output),
        .Data_Valid      (Data_Valid),
        .Busy            (Busy),
        .Overrun         (Overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] po, input logic dv,
                           input logic busy, input logic ovr);
        chk({tag, ".po"},   32'(Parallel_Output), 32'(po));
        chk({tag, ".dv"},   32'(Data_Valid),      32'(dv));
        chk({tag, ".busy"}, 32'(Busy),            32'(busy));
        chk({tag, ".ovr"},  32'(Overrun),         32'(ovr));
    endtask

    // Shift one bit in (Shift high for exactly one cycle).
    task automatic shift_bit(input logic b);
        Serial_Input = b;
        Shift        = 1'b1;
        step();
        Shift        = 1'b0;
    endtask

    // Start followed by 8 back-to-back Shift cycles, MSB first.
    task automatic send_frame(input logic [7:0] w);
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 7; i >= 0; i--) shift_bit(w[i]);
    endtask

    initial begin
        reset = 1'b1; Serial_Input = 1'b0; Start = 1'b0; Shift = 1'b0;
        Sync_Reset = 1'b0; Data_Ack = 1'b0;
        step();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        // Shift and Data_Ack in IDLE do nothing
        Shift = 1'b1; Data_Ack = 1'b1; Serial_Input = 1'b1;
        repeat (3) step();
        Shift = 1'b0; Data_Ack = 1'b0;
        chk_all("idle_noise", 8'h00, 1'b0, 1'b0, 1'b0);

        // A5 frame; Shift in the Start cycle must be ignored
        Start = 1'b1; Shift = 1'b1; Serial_Input = 1'b1;
        step();
        Start = 1'b0; Shift = 1'b0;
        chk("a5_start.busy", 32'(Busy), 32'd1);
        begin
            logic [7:0] a5;
            a5 = 8'hA5;
            for (int i = 7; i >= 1; i--) begin
                shift_bit(a5[i]);
                chk("a5_mid.busy", 32'(Busy), 32'd1);
                chk("a5_mid.dv", 32'(Data_Valid), 32'd0);
            end
            shift_bit(a5[0]);
        end
        chk_all("a5_done", 8'hA5, 1'b1, 1'b0, 1'b0);

        // Start without ack while holding -> overrun, word kept
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk_all("overrun", 8'hA5, 1'b1, 1'b0, 1'b1);

        // Start + ack together -> straight into RECEIVE, overrun kept
        Start = 1'b1; Data_Ack = 1'b1;
        step();
        Start = 1'b0; Data_Ack = 1'b0;
        chk_all("start_ack", 8'hA5, 1'b0, 1'b1, 1'b1);

        // 3C = 0011_1100 with a 3-cycle Shift gap after bit 2; Start ignored in RECEIVE
        shift_bit(1'b0);
        shift_bit(1'b0);
        Start = 1'b1;
        repeat (3) step();
        Start = 1'b0;
        chk_all("gap", 8'hA5, 1'b0, 1'b1, 1'b1);
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b0);
        chk_all("3c_before_last", 8'hA5, 1'b0, 1'b1, 1'b1);
        shift_bit(1'b0);
        chk_all("3c_done", 8'h3C, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-HOLD, checked before any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();

        // A5, overrun, restart, then Sync_Reset after 4 bits
        send_frame(8'hA5);
        chk_all("a5_again", 8'hA5, 1'b1, 1'b0, 1'b0);
        Start = 1'b1;
        step();
        Data_Ack = 1'b1;
        step();
        Start = 1'b0; Data_Ack = 1'b0;
        chk_all("restart", 8'hA5, 1'b0, 1'b1, 1'b1);
        shift_bit(1'b1);
        shift_bit(1'b0);
        shift_bit(1'b1);
        shift_bit(1'b0);
        Sync_Reset = 1'b1; Shift = 1'b1; Start = 1'b1;
        step();
        Sync_Reset = 1'b0; Shift = 1'b0; Start = 1'b0;
        chk_all("sync_reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Shift pulses after Sync_Reset stay ignored until Start
        shift_bit(1'b1);
        chk_all("post_sync_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        send_frame(8'h81);
        chk_all("81_done", 8'h81, 1'b1, 1'b0, 1'b0);

        // Plain ack returns to IDLE
        Data_Ack = 1'b1;
        step();
        Data_Ack = 1'b0;
        chk_all("ack", 8'h81, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("ack_idle", 8'h81, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
